// File: rtl/dds_pkg.sv
// Shared constants for the tuner and the DDS core it feeds.
//   DDS_*       : default address width, tuning range and publish period
//   step_pow10  : step-size lookup, index 0..3 -> 1, 10, 100, 1000
package dds_pkg;

  localparam int DDS_ADDR_W     = 11;
  localparam int DDS_MIN_VAL    = 0;
  localparam int DDS_MAX_VAL    = 1800;
  localparam int DDS_UPDATE_CYC = 2400000;  // 100 ms at 24 MHz

  function automatic int unsigned step_pow10(input logic [1:0] idx);
    case (idx)
      2'd0:    return 1;
      2'd1:    return 10;
      2'd2:    return 100;
      default: return 1000;
    endcase
  endfunction

endpackage

// File: rtl/rotary_tuner_if.sv
// Bundle of the tuner's encoder inputs and published outputs.
//   master : the tuner side (consumes encoder phases, drives Address/FreqChng/StepSel)
//   slave  : the encoder/consumer side
interface rotary_tuner_if
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W
);
  logic              Rot_A;
  logic              Rot_B;
  logic              Rot_C;
  logic [ADDR_W-1:0] Address;
  logic              FreqChng;
  logic [1:0]        StepSel;

  modport master (input Rot_A, Rot_B, Rot_C, output Address, FreqChng, StepSel);
  modport slave  (output Rot_A, Rot_B, Rot_C, input Address, FreqChng, StepSel);
endinterface

// File: rtl/rot_debounce.sv
// Two-flop synchroniser with optional press debounce.
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input
//   sync_o     : synchronised level
//   press_o    : one-clock pulse once din has been stable high for DEB_CYC
//                clocks; never repeats while held. Tied low when DEB_CYC=0.
module rot_debounce #(
  parameter int DEB_CYC = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_o,
  output logic press_o
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sync_o = sync_q[1];

  if (DEB_CYC > 0) begin : g_deb
    localparam int CW = $clog2(DEB_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates at DEB_CYC so a held button yields exactly one pulse;
    // the pulse fires on the DEB_CYC-th consecutive high cycle.
    always_comb begin
      cnt_d   = '0;
      press_o = 1'b0;
      if (sync_q[1]) begin
        cnt_d   = (cnt_q == CW'(DEB_CYC)) ? cnt_q : cnt_q + CW'(1);
        press_o = (cnt_q == CW'(DEB_CYC - 1));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end else begin : g_nodeb
    assign press_o = 1'b0;
  end

endmodule

// File: rtl/rotary_tuner.sv
// Quadrature-encoder tuner for a DDS frequency address.
//   Fg_CLK, RESETn      : clock, async active-low reset
//   Rot_A, Rot_B        : async encoder phases; A falling = detent, B = direction
//   Rot_C               : async push button, cycles the step size
//   Address             : tuning value, republished once per UPDATE_CYC clocks
//   FreqChng            : one-clock pulse coincident with an Address change
//   StepSel             : active step index (0=x1 .. 3=x1000)
module rotary_tuner
  import dds_pkg::*;
#(
  parameter int ADDR_W     = DDS_ADDR_W,
  parameter int MIN_VAL    = DDS_MIN_VAL,
  parameter int MAX_VAL    = DDS_MAX_VAL,
  parameter int N_STEPS    = 3,
  parameter int WRAP       = 0,
  parameter int UPDATE_CYC = DDS_UPDATE_CYC,
  parameter int DEB_CYC    = 240000
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Rot_A,
  input  logic              Rot_B,
  input  logic              Rot_C,
  output logic [ADDR_W-1:0] Address,
  output logic              FreqChng,
  output logic [1:0]        StepSel
);

  localparam int SW = ADDR_W + 1;
  localparam int TW = (UPDATE_CYC > 1) ? $clog2(UPDATE_CYC) : 1;
  localparam logic [ADDR_W-1:0] V_MIN = ADDR_W'(MIN_VAL);
  localparam logic [ADDR_W-1:0] V_MAX = ADDR_W'(MAX_VAL);

  logic a_sync, b_sync, c_sync;
  logic a_press, b_press, c_press;

  rot_debounce #(.DEB_CYC(0)) u_sync_a (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_A), .sync_o(a_sync), .press_o(a_press));
  rot_debounce #(.DEB_CYC(0)) u_sync_b (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_B), .sync_o(b_sync), .press_o(b_press));
  rot_debounce #(.DEB_CYC(DEB_CYC)) u_deb_c (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_C), .sync_o(c_sync), .press_o(c_press));

  logic unused_sig;
  assign unused_sig = ^{a_press, b_press, c_sync};

  logic              a_prev_q, a_prev_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        step_sel_q, step_sel_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              freq_q, freq_d;

  logic          detent, tick;
  logic [SW-1:0] cnt_ext, step_w, sum_up, sum_dn;
  logic          above, below;

  always_comb begin
    a_prev_d = a_sync;
    detent   = a_prev_q & ~a_sync;

    // step_sel_q is the registered value, so a detent in the same cycle as
    // a press naturally uses the old step.
    step_w  = SW'(step_pow10(step_sel_q));
    cnt_ext = {1'b0, count_q};
    sum_up  = cnt_ext + step_w;
    sum_dn  = cnt_ext - step_w;
    above   = sum_up > SW'(MAX_VAL);
    below   = cnt_ext < (step_w + SW'(MIN_VAL));  // avoids relying on borrow

    count_d = count_q;
    if (detent) begin
      if (b_sync) begin
        if (above) count_d = (WRAP != 0) ? V_MIN : V_MAX;
        else       count_d = sum_up[ADDR_W-1:0];
      end else begin
        if (below) count_d = (WRAP != 0) ? V_MAX : V_MIN;
        else       count_d = sum_dn[ADDR_W-1:0];
      end
    end

    step_sel_d = step_sel_q;
    if (c_press)
      step_sel_d = (step_sel_q == 2'(N_STEPS - 1)) ? 2'd0 : step_sel_q + 2'd1;

    tick       = (tick_cnt_q == TW'(UPDATE_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    addr_d = addr_q;
    freq_d = 1'b0;
    if (tick && (count_q != addr_q)) begin
      addr_d = count_q;
      freq_d = 1'b1;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      a_prev_q   <= 1'b0;
      count_q    <= V_MIN;
      step_sel_q <= 2'd0;
      tick_cnt_q <= '0;
      addr_q     <= V_MIN;
      freq_q     <= 1'b0;
    end else begin
      a_prev_q   <= a_prev_d;
      count_q    <= count_d;
      step_sel_q <= step_sel_d;
      tick_cnt_q <= tick_cnt_d;
      addr_q     <= addr_d;
      freq_q     <= freq_d;
    end
  end

  assign Address  = addr_q;
  assign FreqChng = freq_q;
  assign StepSel  = step_sel_q;

endmodule
